// File: rtl/stack_pkg.sv
// stack_pkg: shared op codes, FSM encoding and default width for the stack access controller.
package stack_pkg;
    localparam int STACK_DATA_W = 16;
    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;
    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_MEM,
        S_SPUPD,
        S_ERR
    } state_t;
endpackage

// File: rtl/stack_ack_timer.sv
// stack_ack_timer: counts MEM-wait cycles and flags expiry on the LIMIT-th waiting cycle.
module stack_ack_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] count;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (load)
            count <= '0;
        else if (en)
            count <= count + W'(1);
    end
    assign expired = en && (count == W'(LIMIT - 1));
endmodule

// File: rtl/stack_access_ctrl.sv
// stack_access_ctrl: sequences PUSH/POP/CALL/RET through bounds check, memory access and SP strobe.
module stack_access_ctrl
    import stack_pkg::*;
#(
    parameter int DATA_W = STACK_DATA_W,
    parameter logic [DATA_W-1:0] STACK_LIMIT = 16'hFF00,
    parameter logic [DATA_W-1:0] SP_TOP = 16'hFFFF,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [DATA_W-1:0] op_data,
    input  logic [DATA_W-1:0] sp,
    output logic              sp_push,
    output logic              sp_pop,
    output logic [DATA_W-1:0] sp_new,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_pc_load,
    output logic              err_ovf,
    output logic              err_unf,
    output logic              err_tmo
);
    state_t state, next;
    logic [1:0] op_l;
    logic [DATA_W-1:0] data_l, sp_l;
    logic is_wr, tmo, ovf, unf;

    assign is_wr = (op_l == OP_PUSH) || (op_l == OP_CALL);
    assign ovf = is_wr && (sp_l == STACK_LIMIT);
    assign unf = !is_wr && (sp_l == SP_TOP);

    stack_ack_timer #(.LIMIT(ACK_TIMEOUT)) u_timer (
        .clk(clk),
        .reset(reset),
        .load(state == S_CHECK),
        .en(state == S_MEM),
        .expired(tmo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE:  next = op_valid ? S_CHECK : S_IDLE;
            S_CHECK: next = (ovf || unf) ? S_ERR : S_MEM;
            S_MEM:   next = mem_ack ? S_SPUPD : (tmo ? S_ERR : S_MEM);
            S_SPUPD: next = S_IDLE;
            default: next = S_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_l     <= OP_PUSH;
            data_l   <= '0;
            sp_l     <= '0;
            sp_new   <= SP_TOP;
            res_data <= '0;
            err_ovf  <= 1'b0;
            err_unf  <= 1'b0;
            err_tmo  <= 1'b0;
        end else begin
            if (state == S_IDLE && op_valid) begin
                op_l   <= op_code;
                data_l <= op_data;
                sp_l   <= sp;
            end
            if (state == S_CHECK && ovf)
                err_ovf <= 1'b1;
            if (state == S_CHECK && unf)
                err_unf <= 1'b1;
            // sp_new is registered so it is stable across the whole SPUPD cycle
            if (state == S_MEM && mem_ack) begin
                res_data <= mem_rdata;
                sp_new   <= is_wr ? sp_l - DATA_W'(1) : sp_l + DATA_W'(1);
            end
            if (state == S_MEM && !mem_ack && tmo)
                err_tmo <= 1'b1;
        end
    end

    assign op_ready    = (state == S_IDLE);
    assign mem_req     = (state == S_MEM);
    assign mem_we      = mem_req && is_wr;
    assign mem_addr    = mem_req ? (is_wr ? sp_l : sp_l + DATA_W'(1)) : '0;
    assign mem_wdata   = mem_we ? data_l : '0;
    assign sp_push     = (state == S_SPUPD) && is_wr;
    assign sp_pop      = (state == S_SPUPD) && !is_wr;
    assign res_valid   = sp_pop;
    assign res_pc_load = sp_pop && (op_l == OP_RET);
endmodule
